decoder_seq: RTL



---
 rtl/decoder_pkg.sv | 19 +
 rtl/onehot_decode.sv | 17 +
 rtl/decoder_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for decoder_seq: command modes, FSM states and output-width helper.
package decoder_pkg;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2,
    SCAN  = 2'd3
  } state_e;

  function automatic int out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder; all-zero when en is low.
module onehot_decode
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic                     en,
  input  logic [SEL_W-1:0]         sel,
  output logic [out_w(SEL_W)-1:0]  y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with STATIC / PULSE / SCAN sequencing.
// Build option: define DECODER_SEQ_ACTIVE_LOW_EN to drive y one-cold (idle value all ones).
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int DIV_W     = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [DIV_W-1:0]         div,
  output logic [out_w(SEL_W)-1:0]  y,
  output logic [SEL_W-1:0]         idx,
  output logic                     busy
);

  localparam int         OUT_W     = out_w(SEL_W);
  localparam logic [7:0] PLEN_LAST = 8'(PULSE_LEN - 1);
`ifdef DECODER_SEQ_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] Y_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] Y_IDLE = '0;
`endif

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [7:0]         pcnt_q, pcnt_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               busy_q, busy_d;
  logic               dec_en;
  logic [OUT_W-1:0]   dec_y;

  // A load re-seeds every counter, so an in-flight sequence restarts without a gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pcnt_d  = pcnt_q;
    dec_en  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else if (load) begin
      idx_d  = sel;
      cnt_d  = '0;
      pcnt_d = '0;
      div_d  = div;
      dec_en = 1'b1;
      case (mode)
        MODE_PULSE: state_d = PULSE;
        MODE_SCAN:  state_d = SCAN;
        default:    state_d = HOLD;
      endcase
    end else begin
      case (state_q)
        HOLD: dec_en = 1'b1;
        PULSE: begin
          if (pcnt_q == PLEN_LAST) begin
            state_d = IDLE;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 8'd1;
            dec_en = 1'b1;
          end
        end
        SCAN: begin
          dec_en = 1'b1;
          if (cnt_q == div_q) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == PULSE) || (state_d == SCAN);
  end

  onehot_decode #(.SEL_W(SEL_W)) u_dec (
    .en  (dec_en),
    .sel (idx_d),
    .y   (dec_y)
  );

`ifdef DECODER_SEQ_ACTIVE_LOW_EN
  assign y_d = ~dec_y;
`else
  assign y_d = dec_y;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      pcnt_q  <= '0;
      y_q     <= Y_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pcnt_q  <= pcnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign busy = busy_q;

endmodule
